// File: rtl/instruction_loader.sv
// Byte-serial program loader: assembles MSB-first bytes into words, writes them
// to instruction memory and holds the CPU until a halt word or a full memory.
module instruction_loader #(
  parameter int                 NB_DATA   = 32,
  parameter int                 NB_ADDR   = 8,
  parameter logic [NB_DATA-1:0] HALT_WORD = 32'hFFFFFFFF
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_byte_valid,
  input  logic [7:0]         i_byte,
  output logic               o_byte_ready,
  output logic               o_we,
  output logic [NB_DATA-1:0] o_instr_data,
  output logic [NB_ADDR-1:0] o_addr,
  output logic [NB_ADDR:0]   o_word_count,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_overflow,
  output logic               o_cpu_hold
);

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

  state_t             state, state_nxt;
  logic [NB_DATA-1:0] shift_reg, shift_nxt;
  logic [1:0]         cnt, cnt_nxt;
  logic [NB_ADDR-1:0] addr, addr_nxt;
  logic [NB_ADDR:0]   word_count, wc_nxt;
  logic               overflow, ovf_nxt;
  logic               we, byte_ready, busy, done, cpu_hold;

  // Next-state and datapath update decode
  always_comb begin
    state_nxt = state;
    shift_nxt = shift_reg;
    cnt_nxt   = cnt;
    addr_nxt  = addr;
    wc_nxt    = word_count;
    ovf_nxt   = overflow;
    case (state)
      IDLE, DONE: begin
        if (i_start) begin
          state_nxt = LOAD;
          shift_nxt = '0;
          cnt_nxt   = 2'd0;
          addr_nxt  = '0;
          wc_nxt    = '0;
          ovf_nxt   = 1'b0;
        end else begin
          state_nxt = state;
        end
      end
      LOAD: begin
        // start beats a simultaneous byte: that byte is dropped with the partial word
        if (i_start) begin
          shift_nxt = '0;
          cnt_nxt   = 2'd0;
          addr_nxt  = '0;
          wc_nxt    = '0;
          ovf_nxt   = 1'b0;
        end else if (i_byte_valid) begin
          shift_nxt = {shift_reg[NB_DATA-9:0], i_byte};
          cnt_nxt   = cnt + 2'd1;
          if (cnt == 2'd3) begin
            state_nxt = WRITE;
          end else begin
            state_nxt = LOAD;
          end
        end else begin
          state_nxt = LOAD;
        end
      end
      WRITE: begin
        wc_nxt = word_count + (NB_ADDR+1)'(1);
        // a start seen here lets the write finish, then begins a fresh load
        if (i_start) begin
          state_nxt = LOAD;
          shift_nxt = '0;
          cnt_nxt   = 2'd0;
          addr_nxt  = '0;
          wc_nxt    = '0;
          ovf_nxt   = 1'b0;
        end else if (shift_reg == HALT_WORD) begin
          state_nxt = DONE;
        end else if (addr == {NB_ADDR{1'b1}}) begin
          state_nxt = DONE;
          ovf_nxt   = 1'b1;
        end else begin
          state_nxt = LOAD;
          addr_nxt  = addr + NB_ADDR'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, datapath and registered status outputs
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state      <= IDLE;
      shift_reg  <= '0;
      cnt        <= 2'd0;
      addr       <= '0;
      word_count <= '0;
      overflow   <= 1'b0;
      we         <= 1'b0;
      byte_ready <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cpu_hold   <= 1'b1;
    end else begin
      state      <= state_nxt;
      shift_reg  <= shift_nxt;
      cnt        <= cnt_nxt;
      addr       <= addr_nxt;
      word_count <= wc_nxt;
      overflow   <= ovf_nxt;
      we         <= (state_nxt == WRITE);
      byte_ready <= (state_nxt == LOAD);
      busy       <= (state_nxt == LOAD) || (state_nxt == WRITE);
      done       <= (state_nxt == DONE);
      cpu_hold   <= (state_nxt != DONE);
    end
  end

  assign o_byte_ready = byte_ready;
  assign o_we         = we;
  assign o_instr_data = shift_reg;
  assign o_addr       = addr;
  assign o_word_count = word_count;
  assign o_busy       = busy;
  assign o_done       = done;
  assign o_overflow   = overflow;
  assign o_cpu_hold   = cpu_hold;

endmodule

// File: doc/instruction_loader.md
INSTRUCTION_LOADER -- requirements
Module: instruction_loader

Interface
REQ-001 Parameter NB_DATA, default 32: instruction word width.
REQ-002 Parameter NB_ADDR, default 8: instruction-memory word address width; depth is 2^NB_ADDR words.
REQ-003 Parameter HALT_WORD, default 32'hFFFFFFFF: end-of-program marker word.
REQ-004 The block SHALL use a single clock; reset is synchronous and active-high.
REQ-005 Port `clk`, input, 1 bit: sole clock; all state changes on the rising edge.
REQ-006 Port `i_rst`, input, 1 bit: synchronous, active-high reset.
REQ-007 Port `i_start`, input, 1 bit: begin a new program load.
REQ-008 Port `i_byte_valid`, input, 1 bit: `i_byte` carries a valid byte.
REQ-009 Port `i_byte`, input, 8 bits: program byte stream, most significant byte of each word first.
REQ-010 Port `o_byte_ready`, output, 1 bit: the loader accepts a byte this cycle.
REQ-011 Port `o_we`, output, 1 bit: instruction-memory write enable.
REQ-012 Port `o_instr_data`, output, NB_DATA bits: word to write.
REQ-013 Port `o_addr`, output, NB_ADDR bits: word write address.
REQ-014 Port `o_word_count`, output, NB_ADDR+1 bits: number of words written in the current load.
REQ-015 Port `o_busy`, output, 1 bit: a load is in progress.
REQ-016 Port `o_done`, output, 1 bit: the load has completed.
REQ-017 Port `o_overflow`, output, 1 bit: memory filled before HALT_WORD was received.
REQ-018 Port `o_cpu_hold`, output, 1 bit: drives fetch-stage halt; the CPU must not run.

Function
REQ-019 The FSM SHALL have exactly four states: IDLE, LOAD, WRITE, DONE.
REQ-020 IDLE: `o_byte_ready`=0; `i_start` moves the FSM to LOAD and clears the address, byte counter, `o_word_count` and `o_overflow`.
REQ-021 LOAD: `o_byte_ready`=1; a byte is accepted only when `i_byte_valid` && `o_byte_ready`.
REQ-022 Each accepted byte SHALL shift into the assembly register as {reg[NB_DATA-9:0], i_byte}, and a 2-bit byte counter SHALL increment.
REQ-023 On acceptance of the 4th byte (counter==3), the counter SHALL wrap to 0 and the FSM SHALL enter WRITE on the next edge.
REQ-024 WRITE lasts exactly one cycle with `o_we`=1, `o_instr_data` = the assembled word, `o_addr` = the current address, and `o_byte_ready`=0.
REQ-025 On leaving WRITE, `o_word_count` SHALL increment.
REQ-026 On leaving WRITE, if the word == HALT_WORD, the FSM SHALL go to DONE; the halt word itself is written.
REQ-027 On leaving WRITE, else if `o_addr` == 2^NB_ADDR-1, the FSM SHALL go to DONE and set `o_overflow`=1; the address does not wrap.
REQ-028 On leaving WRITE, otherwise `o_addr` SHALL increment by 1 and the FSM SHALL return to LOAD.
REQ-029 Latency SHALL be: 4th byte accepted at edge N -> `o_we` high during cycle N+1 -> next byte acceptable at cycle N+2.
REQ-030 DONE: `o_done`=1, `o_busy`=0, `o_byte_ready`=0; the FSM holds until `i_start` (go to LOAD, clearing as in REQ-020) or reset.
REQ-031 `o_busy` SHALL be 1 in LOAD and WRITE only.
REQ-032 `o_cpu_hold` SHALL be 1 in IDLE, LOAD and WRITE, and 0 only in DONE.
REQ-033 `i_start` in LOAD SHALL restart the load: the address, byte counter and count are cleared, and any partial word is discarded.
REQ-034 `i_start` in the same cycle as a valid byte SHALL take priority; that byte is not accepted.
REQ-035 `i_start` during WRITE SHALL NOT cancel the write; the restart takes effect on the next cycle.
REQ-036 `i_byte_valid` outside LOAD SHALL be ignored, with no state change.
REQ-037 `o_we` SHALL never be high for two consecutive cycles and never be high outside WRITE.

Reset
REQ-038 While `i_rst`=1 at an edge, the FSM SHALL enter IDLE and all outputs SHALL reset: `o_we`=0, `o_instr_data`=0, `o_addr`=0, `o_word_count`=0, `o_busy`=0, `o_done`=0, `o_overflow`=0, `o_byte_ready`=0, `o_cpu_hold`=1.
REQ-039 Reset SHALL take priority over every other input, including mid-word and during WRITE; a partial word is discarded and no write is issued.

Verification
REQ-040 Reset, then `i_start`, then bytes 20,08,00,05 FF,FF,FF,FF -> writes 32'h20080005 at addr 0 and 32'hFFFFFFFF at addr 1; `o_done`=1, `o_word_count`=2, `o_cpu_hold`=0.
REQ-041 Bytes offered every cycle with `i_byte_valid` held high -> exactly one stall cycle (`o_byte_ready`=0) per word; no byte lost or duplicated.
REQ-042 NB_ADDR=2 with 4 non-halt words -> addresses 0..3 written, `o_overflow`=1, `o_done`=1, `o_addr` stays at 3.
REQ-043 2 bytes into a word, then `i_start` -> next 4 bytes form the word written at addr 0; the earlier bytes are absent from the data.
REQ-044 `i_rst` asserted in the WRITE cycle -> next cycle all outputs at reset values, `o_we`=0; a subsequent load starts at addr 0.
REQ-045 In DONE, `i_byte_valid` pulses -> no writes, state unchanged; `i_start` -> `o_done`=0, `o_busy`=1, `o_word_count`=0.
